regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the register file and shares it between two writeback requesters: ALU (port A) and LSU/multicycle (port B).
- Keeps a per-register busy scoreboard. Issue reserves a destination; the granted writeback clears it.
- Decode sees combinational busy flags for its two source indices so it can stall on RAW hazards.
- Sits between issue/execute/LSU and the register file; drives the file's write-enable, write-index and write-data inputs directly.

---
 rtl/ysyx_24100012_pkg.sv | 14 +
 rtl/rr_arb2.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100012_pkg.sv
// Shared defaults and encodings for the register-file writeback arbiter.
package ysyx_24100012_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_REG_DEF      = 32;
  localparam int INDEX_LEN_DEF  = 5;

  // Writeback port identity; also the encoding of the round-robin history bit.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } wb_port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// port that did not win most recently.
module rr_arb2
  import ysyx_24100012_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_a,
  input  logic     req_b,
  output logic     grant_valid,
  output wb_port_e grant_port
);

  wb_port_e last_grant_q, last_grant_d;

  // Pick the winner this cycle and remember it as the new history.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_port  = PORT_A;
    if (req_a && req_b) begin
      grant_port = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant_port = PORT_B;
    end
    last_grant_d = grant_valid ? grant_port : last_grant_q;
  end

  // History starts as "B won last" so A is favoured first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: arbitrates ALU (A) and LSU (B) writebacks
// and keeps a per-register busy scoreboard for hazard detection.
module regfile_wb_arbiter
  import ysyx_24100012_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_REG      = N_REG_DEF,
  parameter int INDEX_LEN  = INDEX_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_valid,
  input  logic [INDEX_LEN-1:0]  rsv_idx,
  output logic                  rsv_ready,
  input  logic [INDEX_LEN-1:0]  rs1_idx,
  input  logic [INDEX_LEN-1:0]  rs2_idx,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  a_valid,
  input  logic [INDEX_LEN-1:0]  a_idx,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [INDEX_LEN-1:0]  b_idx,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  RegWEn,
  output logic [INDEX_LEN-1:0]  RegWriteIndex,
  output logic [DATA_WIDTH-1:0] RegWriteData,
  output logic [INDEX_LEN:0]    pending_cnt
);

  logic [N_REG-1:0]      busy_q, busy_d;
  logic [INDEX_LEN:0]    pending_cnt_q, pending_cnt_d;
  logic                  grant_valid;
  wb_port_e              grant_port;
  logic [INDEX_LEN-1:0]  wb_idx;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rsv_set;
  logic                  wb_clear;
  logic                  wb_dec;

  // Requests are masked while in reset so no grant or ready leaks out.
  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_a       (a_valid & rst),
    .req_b       (b_valid & rst),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Steer the granted port onto the file's write port; x0 writes are accepted but not enabled.
  always_comb begin
    wb_idx  = '0;
    wb_data = '0;
    if (grant_valid) begin
      if (grant_port == PORT_B) begin
        wb_idx  = b_idx;
        wb_data = b_data;
      end else begin
        wb_idx  = a_idx;
        wb_data = a_data;
      end
    end
    a_ready       = grant_valid && (grant_port == PORT_A);
    b_ready       = grant_valid && (grant_port == PORT_B);
    RegWEn        = grant_valid && (wb_idx != '0);
    RegWriteIndex = wb_idx;
    RegWriteData  = wb_data;
  end

  // Reservation handshake and hazard lookups read only the registered busy state.
  always_comb begin
    rsv_ready = rst && ((rsv_idx == '0) || !busy_q[rsv_idx]);
    rsv_set   = rsv_valid && rsv_ready && (rsv_idx != '0);
    wb_clear  = RegWEn;
    wb_dec    = wb_clear && busy_q[wb_idx];
    rs1_busy  = busy_q[rs1_idx];
    rs2_busy  = busy_q[rs2_idx];
  end

  // Next scoreboard: clear before set, so a fresh reservation survives a stale
  // writeback to the same (non-busy) register in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (wb_clear) begin
      busy_d[wb_idx] = 1'b0;
    end
    if (rsv_set) begin
      busy_d[rsv_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
    pending_cnt_d = pending_cnt_q;
    if (rsv_set && !wb_dec) begin
      pending_cnt_d = pending_cnt_q + {{INDEX_LEN{1'b0}}, 1'b1};
    end else if (!rsv_set && wb_dec) begin
      pending_cnt_d = pending_cnt_q - {{INDEX_LEN{1'b0}}, 1'b1};
    end
  end

  // Scoreboard registers; reset drops every outstanding reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts grants,
// busy flags and the pending count, and expected writes go through a queue.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        rsv_valid;
   logic [4:0]  rsv_idx;
   logic        rsv_ready;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        a_valid;
   logic [4:0]  a_idx;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_idx;
   logic [31:0] b_data;
   logic        b_ready;
   logic        RegWEn;
   logic [4:0]  RegWriteIndex;
   logic [31:0] RegWriteData;
   logic [5:0]  pending_cnt;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     expQ[$];
   logic [31:0] modelBusy;
   int          modelCnt;
   logic        modelLast;
   logic        lastA;
   logic        lastB;
   logic        lastR;
   int          compareCount;
   int          mismatchCount;

   regfile_wb_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .rsv_valid     (rsv_valid),
      .rsv_idx       (rsv_idx),
      .rsv_ready     (rsv_ready),
      .rs1_idx       (rs1_idx),
      .rs2_idx       (rs2_idx),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .a_valid       (a_valid),
      .a_idx         (a_idx),
      .a_data        (a_data),
      .a_ready       (a_ready),
      .b_valid       (b_valid),
      .b_idx         (b_idx),
      .b_data        (b_data),
      .b_ready       (b_ready),
      .RegWEn        (RegWEn),
      .RegWriteIndex (RegWriteIndex),
      .RegWriteData  (RegWriteData),
      .pending_cnt   (pending_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Model state after a reset: nothing busy, A favoured first.
   task automatic modelReset();
      modelBusy = '0;
      modelCnt  = 0;
      modelLast = 1'b1;
      expQ.delete();
   endtask

   // While reset is low every handshake and write output must be quiet.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_a_ready"}, a_ready, 0);
      checkOutput({tag, "_b_ready"}, b_ready, 0);
      checkOutput({tag, "_rsv_ready"}, rsv_ready, 0);
      checkOutput({tag, "_RegWEn"}, RegWEn, 0);
      checkOutput({tag, "_RegWriteIndex"}, RegWriteIndex, 0);
      checkOutput({tag, "_RegWriteData"}, RegWriteData, 0);
      checkOutput({tag, "_pending_cnt"}, pending_cnt, 0);
      checkOutput({tag, "_rs1_busy"}, rs1_busy, 0);
      checkOutput({tag, "_rs2_busy"}, rs2_busy, 0);
   endtask

   // One cycle: drive inputs, predict the outcome, check at the falling edge,
   // then advance the model across the rising edge.
   task automatic applyStimulus(input logic rv, input logic [4:0] ri,
                                input logic av, input logic [4:0] ai, input logic [31:0] ad,
                                input logic bv, input logic [4:0] bi, input logic [31:0] bd,
                                input logic [4:0] r1, input logic [4:0] r2);
      logic    expA;
      logic    expB;
      logic    expRsv;
      logic [4:0] wIdx;
      wb_exp_t e;
      wb_exp_t got;
      rsv_valid = rv;
      rsv_idx   = ri;
      a_valid   = av;
      a_idx     = ai;
      a_data    = ad;
      b_valid   = bv;
      b_idx     = bi;
      b_data    = bd;
      rs1_idx   = r1;
      rs2_idx   = r2;
      expA   = av && (!bv || modelLast);
      expB   = bv && !expA;
      expRsv = (ri == 5'd0) || !modelBusy[ri];
      wIdx   = expA ? ai : bi;
      if (expA || expB) begin
         e.idx  = wIdx;
         e.data = expA ? ad : bd;
         expQ.push_back(e);
      end
      @(negedge clk);
      checkOutput("a_ready", a_ready, expA);
      checkOutput("b_ready", b_ready, expB);
      checkOutput("rsv_ready", rsv_ready, expRsv);
      checkOutput("rs1_busy", rs1_busy, (r1 != 5'd0) && modelBusy[r1]);
      checkOutput("rs2_busy", rs2_busy, (r2 != 5'd0) && modelBusy[r2]);
      checkOutput("pending_cnt", pending_cnt, modelCnt);
      if (a_ready || b_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("sbUnexpectedWrite", {a_ready, b_ready}, 0);
         end else begin
            got = expQ.pop_front();
            checkOutput("RegWriteIndex", RegWriteIndex, got.idx);
            checkOutput("RegWriteData", RegWriteData, got.data);
            checkOutput("RegWEn", RegWEn, got.idx != 5'd0);
         end
      end else begin
         checkOutput("idleRegWEn", RegWEn, 0);
         checkOutput("idleRegWriteIndex", RegWriteIndex, 0);
         checkOutput("idleRegWriteData", RegWriteData, 0);
      end
      checkOutput("sbDrain", expQ.size(), 0);
      lastA = expA;
      lastB = expB;
      lastR = rv && expRsv;
      @(posedge clk);
      if ((expA || expB) && wIdx != 5'd0) begin
         if (modelBusy[wIdx]) modelCnt--;
         modelBusy[wIdx] = 1'b0;
      end
      if (rv && expRsv && ri != 5'd0) begin
         modelBusy[ri] = 1'b1;
         modelCnt++;
      end
      if (expA || expB) modelLast = expB;
      #1;
   endtask

   // Directed scenarios first, then a reset in the middle of traffic, then a
   // randomised stretch where ungranted requests are held stable.
   initial begin
      logic        aP;
      logic        bP;
      logic        rP;
      logic [4:0]  aI;
      logic [4:0]  bI;
      logic [4:0]  rI;
      logic [31:0] aD;
      logic [31:0] bD;
      compareCount  = 0;
      mismatchCount = 0;
      modelReset();
      rst       = 1'b0;
      rsv_valid = 1'b1;
      rsv_idx   = 5'd6;
      a_valid   = 1'b1;
      a_idx     = 5'd3;
      a_data    = 32'h11;
      b_valid   = 1'b1;
      b_idx     = 5'd4;
      b_data    = 32'h22;
      rs1_idx   = 5'd6;
      rs2_idx   = 5'd4;
      #2;
      checkResetState("reset");
      rsv_valid = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      #10 rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] both ports valid: A, then B, then A again");
      applyStimulus(0, 0, 1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
      applyStimulus(0, 0, 1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
      applyStimulus(0, 0, 1, 3, 32'h33, 1, 4, 32'h44, 3, 4);

      $display("[TB] reserve x5 and retire it through port A");
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
      applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);

      $display("[TB] WAW stall on x7 released by port B");
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      applyStimulus(1, 7, 0, 0, 0, 1, 7, 32'h77, 7, 0);
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      applyStimulus(0, 0, 1, 7, 32'h7777, 0, 0, 0, 7, 0);

      $display("[TB] x0 writes and reservations");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] reset in the middle of traffic");
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 2);
      applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 1, 2);
      rsv_valid = 1'b1;
      rsv_idx   = 5'd9;
      a_valid   = 1'b1;
      a_idx     = 5'd1;
      a_data    = 32'hA1;
      b_valid   = 1'b1;
      b_idx     = 5'd2;
      b_data    = 32'hB2;
      rs1_idx   = 5'd1;
      rs2_idx   = 5'd2;
      #2 rst = 1'b0;
      #1;
      checkResetState("midReset");
      @(posedge clk);
      #1;
      checkResetState("heldReset");
      rsv_valid = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      #3 rst = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      applyStimulus(0, 0, 1, 3, 32'h55, 1, 4, 32'h66, 1, 2);

      $display("[TB] randomised traffic");
      aP = 1'b0;
      bP = 1'b0;
      rP = 1'b0;
      aI = '0;
      bI = '0;
      rI = '0;
      aD = '0;
      bD = '0;
      for (int i = 0; i < 80; i++) begin
         if (!aP && $urandom_range(0, 1) == 1) begin
            aP = 1'b1;
            aI = 5'($urandom_range(0, 7));
            aD = $urandom;
         end
         if (!bP && $urandom_range(0, 1) == 1) begin
            bP = 1'b1;
            bI = 5'($urandom_range(0, 7));
            bD = $urandom;
         end
         if (!rP && $urandom_range(0, 1) == 1) begin
            rP = 1'b1;
            rI = 5'($urandom_range(0, 7));
         end
         applyStimulus(rP, rI, aP, aI, aD, bP, bI, bD,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (lastA) aP = 1'b0;
         if (lastB) bP = 1'b0;
         if (lastR) rP = 1'b0;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
